// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, and
// holds each fetched word in a valid/ready register toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  input  logic        i_halt,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_target,
  output logic        o_halted,
  output logic        o_misaligned,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED, FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        drop_q, drop_d;
  logic        ivld_q, ivld_d;
  logic        halted_q, halted_d;
  logic        mis_q, mis_d;

  logic rsp, hs, redir, tgt_mis;

  assign rsp     = i_imem_valid & req_q;
  assign hs      = ivld_q & i_inst_ready;
  assign redir   = i_redirect & ((state_q == FETCH) | (state_q == HOLD));
  assign tgt_mis = |i_redirect_target[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    drop_d     = drop_q;
    ivld_d     = ivld_q;
    halted_d   = halted_q;
    mis_d      = mis_q;

    if (redir) begin
      // redirect beats a same-cycle response or handshake
      ivld_d = 1'b0;
      if (tgt_mis) begin
        state_d = FAULT;
        mis_d   = 1'b1;
        drop_d  = 1'b0;
        req_d   = req_q & ~rsp;
      end else begin
        state_d = FETCH;
        pc_d    = i_redirect_target;
        if (req_q & ~rsp) begin
          drop_d = 1'b1;
        end else begin
          drop_d     = 1'b0;
          req_d      = 1'b1;
          req_addr_d = i_redirect_target;
        end
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (!req_q) begin
            req_d      = 1'b1;
            req_addr_d = pc_q;
          end else if (rsp) begin
            if (drop_q) begin
              drop_d     = 1'b0;
              req_addr_d = pc_q;
            end else begin
              inst_d    = i_imem_rdata;
              inst_pc_d = req_addr_q;
              ivld_d    = 1'b1;
              pc_d      = pc_q + 32'd4;
              req_d     = 1'b0;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (hs) begin
            cnt_d  = cnt_q + 32'd1;
            ivld_d = 1'b0;
            if (i_halt) begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end else begin
              state_d    = FETCH;
              req_d      = 1'b1;
              req_addr_d = pc_q;
            end
          end
        end
        // keep the request up until the in-flight response is absorbed
        FAULT:   req_d = req_q & ~i_imem_valid;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_ADDR;
      req_addr_q <= 32'd0;
      inst_q     <= 32'd0;
      inst_pc_q  <= 32'd0;
      cnt_q      <= 32'd0;
      req_q      <= 1'b0;
      drop_q     <= 1'b0;
      ivld_q     <= 1'b0;
      halted_q   <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      drop_q     <= drop_d;
      ivld_q     <= ivld_d;
      halted_q   <= halted_d;
      mis_q      <= mis_d;
    end
  end

  assign o_imem_req    = req_q;
  assign o_imem_addr   = req_addr_q;
  assign o_inst_valid  = ivld_q;
  assign o_inst        = inst_q;
  assign o_inst_pc     = inst_pc_q;
  assign o_halted      = halted_q;
  assign o_misaligned  = mis_q;
  assign o_fetch_count = cnt_q;

  // interface stability the memory and decode sides rely on
  assert property (@(posedge i_clk) disable iff (i_rst)
    (req_q && !rsp) |=> (req_q || state_q == FAULT) && $stable(req_addr_q));
  assert property (@(posedge i_clk) disable iff (i_rst)
    (ivld_q && !i_inst_ready && !i_redirect) |=> ivld_q && $stable(inst_q) && $stable(inst_pc_q));

endmodule
